arbitro_memoria: RTL and testbench



---
 rtl/memoria_pkg.sv | 14 +
 rtl/rr_arbitro2.sv | 18 +
 rtl/arbitro_memoria.sv | 126 ++++++++++++
 tb/tb_arbitro_memoria.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/memoria_pkg.sv
// Shared types and defaults for the memoria arbiter: FSM state encoding and
// the default memory geometry.
package memoria_pkg;

    localparam int NWORDS_DEF = 40;
    localparam int DW_DEF     = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbitro2.sv
// Two-requester round-robin pick: on contention the port that did not win
// last time gets the grant. Purely combinational; the history bit is external.
module rr_arbitro2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req0 && req1)
            grant = last ? 2'b01 : 2'b10;
        else
            grant = {req1, req0};
    end

endmodule

// File: rtl/arbitro_memoria.sv
// Serialises two request ports onto the single-ported memoria: IDLE picks a
// winner, ACCESS drives the memory for one cycle, RESP returns the result.
module arbitro_memoria
    import memoria_pkg::*;
#(
    parameter int NWORDS = NWORDS_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [31:0]   addr0,
    input  logic [31:0]   addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err0,
    output logic          err1,
    output logic          mem_memwrite,
    output logic          mem_memread,
    output logic          mem_memtoreg,
    output logic [31:0]   mem_aluresult,
    output logic [DW-1:0] mem_valor2,
    input  logic [DW-1:0] mem_valorsalvar
);

    state_t        state, state_nxt;
    logic          last;
    logic          owner;
    logic          cur_we;
    logic [31:0]   cur_addr;
    logic [DW-1:0] cur_wdata;
    logic [1:0]    grant;
    logic          in_range;

    rr_arbitro2 u_rr (
        .req0  (req0),
        .req1  (req1),
        .last  (last),
        .grant (grant)
    );

    assign in_range     = cur_addr < 32'(NWORDS);
    assign mem_memtoreg = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Memory controls are decoded from state so reset silences them at once.
    always_comb begin
        state_nxt     = state;
        mem_memwrite  = 1'b0;
        mem_memread   = 1'b0;
        mem_aluresult = '0;
        mem_valor2    = '0;
        case (state)
            IDLE:   if (|grant) state_nxt = ACCESS;
            ACCESS: begin
                mem_aluresult = cur_addr;
                mem_valor2    = cur_wdata;
                mem_memwrite  = cur_we & in_range;
                mem_memread   = ~cur_we & in_range;
                state_nxt     = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last      <= 1'b1;
            owner     <= 1'b0;
            cur_we    <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            if (state == IDLE && |grant) begin
                owner     <= grant[1];
                last      <= grant[1];
                cur_we    <= grant[1] ? we1    : we0;
                cur_addr  <= grant[1] ? addr1  : addr0;
                cur_wdata <= grant[1] ? wdata1 : wdata0;
                gnt0      <= grant[0];
                gnt1      <= grant[1];
            end
            // Writes complete with rvalid but leave the port's rdata untouched.
            if (state == RESP) begin
                if (owner) begin
                    rvalid1 <= 1'b1;
                    err1    <= ~in_range;
                    if (!cur_we) rdata1 <= in_range ? mem_valorsalvar : '0;
                end else begin
                    rvalid0 <= 1'b1;
                    err0    <= ~in_range;
                    if (!cur_we) rdata0 <= in_range ? mem_valorsalvar : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_arbitro_memoria.sv
// Scoreboard bench for arbitro_memoria: behavioural memory, a reference model
// that predicts grants and completions, and a monitor that checks them.
module tb_arbitro_memoria;

    localparam int NW = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_memwrite, mem_memread, mem_memtoreg;
    logic [31:0] mem_aluresult, mem_valor2;
    logic [31:0] mem_valorsalvar;

    arbitro_memoria #(.NWORDS(NW), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
        .mem_memtoreg(mem_memtoreg), .mem_aluresult(mem_aluresult),
        .mem_valor2(mem_valor2), .mem_valorsalvar(mem_valorsalvar)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stand-in for memoria: power-up word i holds i+5, registered read port.
    bit        mem_written [NW];
    bit [31:0] mem_wr      [NW];
    bit [31:0] valorsalvar_q;
    assign mem_valorsalvar = valorsalvar_q;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_memwrite) begin
            mem_written[mem_aluresult] <= 1'b1;
            mem_wr[mem_aluresult]      <= mem_valor2;
        end
        if (mem_memread)
            valorsalvar_q <= mem_written[mem_aluresult] ? mem_wr[mem_aluresult]
                                                        : mem_aluresult + 32'd5;
    end

    // Reference model: whole-memory view, last grant, held rdata per port.
    bit        ref_written [NW];
    bit [31:0] ref_wr      [NW];
    bit        m_last = 1'b1;
    bit [31:0] m_rdata [2];

    typedef struct {
        bit [31:0] rdata;
        bit        err;
        int        due;
    } exp_t;
    exp_t exp_q0 [$];
    exp_t exp_q1 [$];

    logic [1:0] rq_s;
    always @(posedge clk) rq_s <= {req1, req0};

    function automatic bit [31:0] ref_rd(input bit [31:0] a);
        return ref_written[a] ? ref_wr[a] : a + 32'd5;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (rvalid0 || rvalid1) begin
                exp_t e;
                int   p;
                p = rvalid1 ? 1 : 0;
                chk("rvalid_onehot", {rvalid1, rvalid0}, p ? 2'b10 : 2'b01);
                if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
                    chk("unexpected_rvalid", {rvalid1, rvalid0}, 2'b00);
                end else begin
                    e = p ? exp_q1.pop_front() : exp_q0.pop_front();
                    chk($sformatf("rdata%0d", p), p ? rdata1 : rdata0, e.rdata);
                    chk($sformatf("err%0d", p), p ? err1 : err0, e.err);
                    chk($sformatf("rvalid%0d_cycle", p), cyc, e.due);
                end
                chk("idle_aluresult", mem_aluresult, 0);
            end
            if (gnt0 || gnt1) begin
                int        w;
                bit        we, inr;
                bit [31:0] a, d, rd;
                if (rq_s == 2'b11) w = m_last ? 0 : 1;
                else               w = rq_s[1] ? 1 : 0;
                if (rq_s == 2'b00) chk("grant_without_request", {gnt1, gnt0}, 2'b00);
                else               chk("grant_port", {gnt1, gnt0}, w ? 2'b10 : 2'b01);
                m_last = w[0];
                we  = w ? we1 : we0;
                a   = w ? addr1 : addr0;
                d   = w ? wdata1 : wdata0;
                inr = a < NW;
                chk("mem_memwrite", mem_memwrite, we & inr);
                chk("mem_memread", mem_memread, ~we & inr);
                chk("mem_aluresult", mem_aluresult, a);
                chk("mem_valor2", mem_valor2, d);
                chk("mem_memtoreg", mem_memtoreg, 1'b1);
                if (we) begin
                    if (inr) begin ref_written[a] = 1'b1; ref_wr[a] = d; end
                    rd = m_rdata[w];
                end else begin
                    rd = inr ? ref_rd(a) : 32'd0;
                end
                m_rdata[w] = rd;
                if (w) exp_q1.push_back('{rd, ~inr, cyc + 2});
                else   exp_q0.push_back('{rd, ~inr, cyc + 2});
            end
        end
    end

    task automatic check_quiet(input string tag);
        chk({tag, "_ctl"}, {gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_memwrite, mem_memread}, 0);
        chk({tag, "_rdata"}, {rdata1, rdata0}, 0);
        chk({tag, "_mem_bus"}, {mem_aluresult, mem_valor2}, 0);
        chk({tag, "_memtoreg"}, mem_memtoreg, 1'b1);
    endtask

    task automatic do_txn(input int p, input bit we, input bit [31:0] a, input bit [31:0] d);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = (p == 0) ? gnt0 : gnt1;
        end
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        if (!got) chk($sformatf("gnt%0d_timeout", p), 1'b0, 1'b1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rand_port(input int p, input int n);
        bit [31:0] a;
        for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 9))
                7:       a = 32'd40;
                8:       a = 32'hFFFF_FFFF;
                9:       a = $urandom;
                default: a = $urandom_range(0, NW - 1);
            endcase
            do_txn(p, $urandom_range(0, 1) == 1, a, $urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        {req0, req1, we0, we1} = '0;
        {addr0, addr1, wdata0, wdata1} = '0;
        idle_cycles(3);
        check_quiet("reset");
        reset = 1'b0;

        do_txn(0, 1'b0, 32'd16, 32'd0);
        idle_cycles(3);
        do_txn(1, 1'b1, 32'd5, 32'hDEAD);
        idle_cycles(3);
        do_txn(1, 1'b0, 32'd5, 32'd0);
        idle_cycles(3);

        fork
            begin do_txn(0, 1'b0, 32'd1, 0); do_txn(0, 1'b0, 32'd2, 0); end
            begin do_txn(1, 1'b0, 32'd3, 0); do_txn(1, 1'b0, 32'd4, 0); end
        join
        idle_cycles(3);

        do_txn(0, 1'b0, 32'd40, 0);
        idle_cycles(3);
        do_txn(0, 1'b0, 32'hFFFF_FFFF, 0);
        idle_cycles(3);

        // Reset lands in RESP of a write: memory keeps it, no completion.
        do_txn(0, 1'b1, 32'd3, 32'h1234_5678);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        check_quiet("midreset");
        exp_q0.delete();
        exp_q1.delete();
        m_last     = 1'b1;
        m_rdata[0] = 0;
        m_rdata[1] = 0;
        idle_cycles(2);
        reset = 1'b0;
        idle_cycles(2);
        do_txn(0, 1'b0, 32'd3, 0);
        idle_cycles(3);
        fork
            do_txn(1, 1'b0, 32'd7, 0);
            do_txn(0, 1'b0, 32'd8, 0);
        join
        idle_cycles(4);

        fork
            rand_port(0, 40);
            rand_port(1, 40);
        join

        for (int i = 0; i < 20 && (exp_q0.size() + exp_q1.size()) != 0; i++) @(negedge clk);
        chk("pending_port0", exp_q0.size(), 0);
        chk("pending_port1", exp_q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
